// File: rtl/fp_lut_sched_pkg.sv
// Shared types and helpers for the bit-serial FP LUT array scheduler.
// Used by fp_lut_array_sched and, with FP_LUT_SCHED_PERF_EN, fp_lut_sched_perf_cnt.
package fp_lut_sched_pkg;

    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } sched_state_e;

    // A zero count still runs one tile; oversize requests saturate at the array depth.
    function automatic int clamp_ktiles(input int raw, input int max_k);
        if (raw == 0) begin
            return 1;
        end else if (raw > max_k) begin
            return max_k;
        end
        return raw;
    endfunction

endpackage

// File: rtl/fp_lut_sched_perf_cnt.sv
// Saturating event counter with synchronous clear, used for scheduler
// performance monitoring when FP_LUT_SCHED_PERF_EN is defined.
module fp_lut_sched_perf_cnt
    import fp_lut_sched_pkg::*;
#(
    parameter int W = PERF_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fp_lut_array_sched.sv
// Sequencer for the bit-serial FP LUT array: fetches K tiles, steps B_BIT planes
// per tile, then holds the result. FP_LUT_SCHED_PERF_EN adds perf_busy/perf_stall.
module fp_lut_array_sched
    import fp_lut_sched_pkg::*;
#(
    parameter int B_BIT      = 2,
    parameter int MAX_KTILES = 16,
    parameter int BI_W       = (B_BIT > 1) ? $clog2(B_BIT) : 1,
    parameter int KT_W       = $clog2(MAX_KTILES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [KT_W-1:0] cmd_ktiles,
    output logic            tile_req,
    input  logic            tile_valid,
    output logic            tile_done,
    output logic            dp_en,
    output logic [BI_W-1:0] dp_b_index,
    output logic            dp_first,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
`ifdef FP_LUT_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_busy,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam logic [BI_W-1:0] LAST_PLANE = BI_W'(B_BIT - 1);

    sched_state_e    state_q;
    logic [BI_W-1:0] plane_q;
    logic [KT_W-1:0] ktile_q;
    logic [KT_W-1:0] ktiles_q;
    logic [KT_W-1:0] ktiles_d;
    logic            last_plane;
    logic            last_tile;

    assign ktiles_d   = KT_W'(clamp_ktiles(int'(cmd_ktiles), MAX_KTILES));
    assign last_plane = (plane_q == LAST_PLANE);
    assign last_tile  = (ktile_q == (ktiles_q - KT_W'(1)));

    // NOTE: non-blocking assignments so every branch sees the pre-edge state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            plane_q  <= '0;
            ktile_q  <= '0;
            ktiles_q <= KT_W'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        ktiles_q <= ktiles_d;
                        ktile_q  <= '0;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    if (tile_valid) begin
                        plane_q <= '0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (last_plane) begin
                        plane_q <= '0;
                        if (last_tile) begin
                            state_q <= DRAIN;
                        end else begin
                            ktile_q <= ktile_q + KT_W'(1);
                            state_q <= FETCH;
                        end
                    end else begin
                        plane_q <= plane_q + BI_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only; rst forces them quiet so an
    // aborted run never emits a tile_done or out_valid while being reset.
    logic computing;
    assign computing  = !rst && (state_q == COMPUTE);

    assign cmd_ready  = !rst && (state_q == IDLE);
    assign tile_req   = !rst && (state_q == FETCH);
    assign out_valid  = !rst && (state_q == DRAIN);
    assign busy       = !rst && (state_q != IDLE);
    assign dp_en      = computing;
    assign dp_b_index = computing ? plane_q : '0;
    assign dp_first   = computing && (plane_q == '0) && (ktile_q == '0);
    assign tile_done  = computing && last_plane;

`ifdef FP_LUT_SCHED_PERF_EN
    logic stall_ev;
    assign stall_ev = ((state_q == FETCH) && !tile_valid) ||
                      ((state_q == DRAIN) && !out_ready);

    fp_lut_sched_perf_cnt #(.W(PERF_W)) u_perf_busy (
        .clk (clk),
        .clr (rst),
        .en  (state_q != IDLE),
        .cnt (perf_busy)
    );

    fp_lut_sched_perf_cnt #(.W(PERF_W)) u_perf_stall (
        .clk (clk),
        .clr (rst),
        .en  (stall_ev),
        .cnt (perf_stall)
    );
`endif

endmodule

// File: tb/tb_fp_lut_array_sched.sv
// Self-checking bench: three scheduler instances (B_BIT = 2, 4, 1) driven from
// per-cycle vector tables built by a transaction-level model of the scheduling rules.
module tb_fp_lut_array_sched;

    localparam int MAXK = 16;
    localparam int KTW  = 5;
    localparam int NU   = 3;

    typedef struct {
        logic           rst;
        logic           cmd_valid;
        logic [KTW-1:0] cmd_ktiles;
        logic           tile_valid;
        logic           out_ready;
        logic           e_cmd_ready;
        logic           e_tile_req;
        logic           e_tile_done;
        logic           e_dp_en;
        logic [1:0]     e_bidx;
        logic           e_dp_first;
        logic           e_out_valid;
        logic           e_busy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           i_rst        [NU];
    logic           i_cmd_valid  [NU];
    logic [KTW-1:0] i_ktiles     [NU];
    logic           i_tile_valid [NU];
    logic           i_out_ready  [NU];

    logic           o_cmd_ready [NU];
    logic           o_tile_req  [NU];
    logic           o_tile_done [NU];
    logic           o_dp_en     [NU];
    logic [1:0]     o_bidx      [NU];
    logic           o_dp_first  [NU];
    logic           o_out_valid [NU];
    logic           o_busy      [NU];
`ifdef FP_LUT_SCHED_PERF_EN
    logic [31:0]    o_pbusy     [NU];
    logic [31:0]    o_pstall    [NU];
`endif

    for (genvar g = 0; g < NU; g++) begin : g_dut
        localparam int BB = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        localparam int BW = (BB > 1) ? $clog2(BB) : 1;
        logic [BW-1:0] bix;

        fp_lut_array_sched #(.B_BIT(BB), .MAX_KTILES(MAXK)) u_dut (
            .clk        (clk),
            .rst        (i_rst[g]),
            .cmd_valid  (i_cmd_valid[g]),
            .cmd_ready  (o_cmd_ready[g]),
            .cmd_ktiles (i_ktiles[g]),
            .tile_req   (o_tile_req[g]),
            .tile_valid (i_tile_valid[g]),
            .tile_done  (o_tile_done[g]),
            .dp_en      (o_dp_en[g]),
            .dp_b_index (bix),
            .dp_first   (o_dp_first[g]),
            .out_valid  (o_out_valid[g]),
            .out_ready  (i_out_ready[g]),
            .busy       (o_busy[g])
`ifdef FP_LUT_SCHED_PERF_EN
            ,
            .perf_busy  (o_pbusy[g]),
            .perf_stall (o_pstall[g])
`endif
        );

        assign o_bidx[g] = 2'(bix);
    end

    int   checks   = 0;
    int   failures = 0;
    vec_t vq[$];

    task automatic check(input int u, input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s vec%0d got=%0h want=%0h", u, name, idx, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic push_reset();
        vec_t v;
        v = blank();
        v.rst = 1'b1;
        vq.push_back(v);
        vq.push_back(v);
    endtask

    task automatic push_idle();
        vec_t v;
        v = blank();
        v.e_cmd_ready = 1'b1;
        v.out_ready   = 1'($urandom);
        v.tile_valid  = 1'($urandom);
        vq.push_back(v);
    endtask

    // One command from acceptance to result handshake, expressed directly from
    // the scheduling rules: per tile (stall + 1) fetch cycles then bb planes,
    // then (drain stall + 1) result cycles. Optional reset abort at (ab_tile, ab_plane).
    task automatic push_txn(input int bb, input int kraw, input bit rnd,
                            input int st_tile, input int st_len, input int dr_len,
                            input int ab_tile, input int ab_plane);
        vec_t v;
        int   k;
        int   s;
        int   d;
        k = (kraw == 0) ? 1 : ((kraw > MAXK) ? MAXK : kraw);

        v = blank();
        v.cmd_valid   = 1'b1;
        v.cmd_ktiles  = KTW'(kraw);
        v.e_cmd_ready = 1'b1;
        v.tile_valid  = 1'($urandom);
        v.out_ready   = 1'($urandom);
        vq.push_back(v);

        for (int j = 0; j < k; j++) begin
            s = rnd ? int'($urandom_range(0, 2)) : ((j == st_tile) ? st_len : 0);
            for (int i = 0; i < s; i++) begin
                v = blank();
                v.cmd_valid  = 1'($urandom);
                v.out_ready  = 1'($urandom);
                v.e_tile_req = 1'b1;
                v.e_busy     = 1'b1;
                vq.push_back(v);
            end
            v = blank();
            v.cmd_valid  = 1'($urandom);
            v.tile_valid = 1'b1;
            v.e_tile_req = 1'b1;
            v.e_busy     = 1'b1;
            vq.push_back(v);
            for (int p = 0; p < bb; p++) begin
                v = blank();
                v.cmd_valid = 1'($urandom);
                if (j == ab_tile && p == ab_plane) begin
                    v.rst = 1'b1;
                    vq.push_back(v);
                    return;
                end
                v.tile_valid  = 1'($urandom);
                v.out_ready   = 1'($urandom);
                v.e_dp_en     = 1'b1;
                v.e_bidx      = 2'(p);
                v.e_dp_first  = (p == 0) && (j == 0);
                v.e_tile_done = (p == bb - 1);
                v.e_busy      = 1'b1;
                vq.push_back(v);
            end
        end

        d = rnd ? int'($urandom_range(0, 3)) : dr_len;
        for (int i = 0; i < d; i++) begin
            v = blank();
            v.cmd_valid   = 1'b1;
            v.tile_valid  = 1'($urandom);
            v.e_out_valid = 1'b1;
            v.e_busy      = 1'b1;
            vq.push_back(v);
        end
        v = blank();
        v.cmd_valid   = 1'($urandom);
        v.out_ready   = 1'b1;
        v.e_out_valid = 1'b1;
        v.e_busy      = 1'b1;
        vq.push_back(v);
    endtask

    task automatic run_table(input int u);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            i_rst[u]        = vq[i].rst;
            i_cmd_valid[u]  = vq[i].cmd_valid;
            i_ktiles[u]     = vq[i].cmd_ktiles;
            i_tile_valid[u] = vq[i].tile_valid;
            i_out_ready[u]  = vq[i].out_ready;
            @(negedge clk);
            check(u, "cmd_ready",  i, 32'(o_cmd_ready[u]), 32'(vq[i].e_cmd_ready));
            check(u, "tile_req",   i, 32'(o_tile_req[u]),  32'(vq[i].e_tile_req));
            check(u, "tile_done",  i, 32'(o_tile_done[u]), 32'(vq[i].e_tile_done));
            check(u, "dp_en",      i, 32'(o_dp_en[u]),     32'(vq[i].e_dp_en));
            check(u, "dp_b_index", i, 32'(o_bidx[u]),      32'(vq[i].e_bidx));
            check(u, "dp_first",   i, 32'(o_dp_first[u]),  32'(vq[i].e_dp_first));
            check(u, "out_valid",  i, 32'(o_out_valid[u]), 32'(vq[i].e_out_valid));
            check(u, "busy",       i, 32'(o_busy[u]),      32'(vq[i].e_busy));
        end
        vq.delete();
    endtask

    task automatic drive_idle(input int u);
        @(posedge clk);
        #1;
        i_rst[u]        = 1'b0;
        i_cmd_valid[u]  = 1'b0;
        i_ktiles[u]     = '0;
        i_tile_valid[u] = 1'b0;
        i_out_ready[u]  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            i_rst[u]        = 1'b1;
            i_cmd_valid[u]  = 1'b0;
            i_ktiles[u]     = '0;
            i_tile_valid[u] = 1'b0;
            i_out_ready[u]  = 1'b0;
        end

        // B_BIT=2: basic latency, long drain, reset abort, count clamping, random traffic.
        push_reset();
        push_idle();
        push_txn(2, 1, 1'b0, -1, 0, 0, -1, -1);
        push_txn(2, 1, 1'b0, -1, 0, 7, -1, -1);
        push_txn(2, 2, 1'b0, -1, 0, 0, 1, 1);
        push_idle();
        push_txn(2, 2, 1'b0, -1, 0, 0, -1, -1);
        push_txn(2, 0, 1'b0, -1, 0, 0, -1, -1);
        push_txn(2, MAXK + 5, 1'b0, -1, 0, 0, -1, -1);
        for (int t = 0; t < 20; t++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) push_idle();
            push_txn(2, int'($urandom_range(0, 6)), 1'b1, -1, 0, 0, -1, -1);
        end
        run_table(0);
        drive_idle(0);

        // B_BIT=4: three tiles with a 5-cycle operand stall before the second tile.
        push_reset();
        push_idle();
        push_txn(4, 3, 1'b0, 1, 5, 0, -1, -1);
        run_table(1);
        drive_idle(1);
`ifdef FP_LUT_SCHED_PERF_EN
        check(1, "perf_stall", 0, o_pstall[1], 32'd5);
        check(1, "perf_busy",  0, o_pbusy[1],  32'd21);
`endif
        for (int t = 0; t < 5; t++) begin
            push_txn(4, int'($urandom_range(0, 4)), 1'b1, -1, 0, 0, -1, -1);
        end
        run_table(1);
        drive_idle(1);

        // B_BIT=1: every compute cycle is the last plane.
        push_reset();
        push_idle();
        push_txn(1, 2, 1'b0, -1, 0, 0, -1, -1);
        for (int t = 0; t < 10; t++) begin
            push_txn(1, int'($urandom_range(0, 5)), 1'b1, -1, 0, 0, -1, -1);
        end
        run_table(2);
        drive_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
